// File: rtl/slot_machine_core_if.sv
// rtl/slot_machine_core_if.sv - button pulses in, game status and reel digits out
// Master drives the synchronised button pulses; slave is the game engine.
interface slot_machine_core_if #(
   parameter int NUM_REELS = 3,
   parameter int NUM_MODES = 3,
   parameter int CREDIT_W  = 8
);
   localparam int MODE_W = $clog2(NUM_MODES + 1);

   logic                   mode;
   logic                   start;
   logic                   betinp;
   logic                   betinm;
   logic [MODE_W-1:0]      mode_num;
   logic [3:0]             bet;
   logic [CREDIT_W-1:0]    credit;
   logic                   won;
   logic                   busy;
   logic [4*NUM_REELS-1:0] out;

   modport master (
      output mode, start, betinp, betinm,
      input  mode_num, bet, credit, won, busy, out
   );

   modport slave (
      input  mode, start, betinp, betinm,
      output mode_num, bet, credit, won, busy, out
   );
endinterface

// File: rtl/slot_machine_core.sv
// rtl/slot_machine_core.sv - clocked slot machine engine: reels, modes, bet and credit
// One FSM (IDLE/SPIN/EVAL/PAYOUT) owns all state; every output comes straight from a register.
module slot_machine_core #(
   parameter int NUM_REELS   = 3,
   parameter int NUM_MODES   = 3,
   parameter int SPIN_CYCLES = 16,
   parameter int BET_MAX     = 9,
   parameter int CREDIT_W    = 8,
   parameter int INIT_CREDIT = 20,
   parameter int JACKPOT_MUL = 8
) (
   input  logic               clk,
   input  logic               rst,
   slot_machine_core_if.slave bus
);
   localparam int MODE_W = $clog2(NUM_MODES + 1);
   localparam int TOTAL  = SPIN_CYCLES * NUM_REELS;
   localparam int CNT_W  = $clog2(TOTAL + 1);
   localparam logic [31:0] CREDIT_MAX = 32'((64'd1 << CREDIT_W) - 64'd1);

   typedef enum logic [1:0] {IDLE, SPIN, EVAL, PAYOUT} state_t;

   state_t                 state_q, state_d;
   logic [MODE_W-1:0]      mode_q, mode_d;
   logic [3:0]             bet_q, bet_d;
   logic [CREDIT_W-1:0]    credit_q, credit_d;
   logic                   won_q, won_d;
   logic                   busy_q, busy_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [4*NUM_REELS-1:0] reels_q, reels_d;
   logic [31:0]            win_q, win_d;

   logic        all_eq, adj_eq;
   logic [31:0] jack, sum;
   logic [4:0]  step_sum;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         mode_q   <= MODE_W'(1);
         bet_q    <= 4'd1;
         credit_q <= CREDIT_W'(INIT_CREDIT);
         won_q    <= 1'b0;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         reels_q  <= '0;
         win_q    <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         bet_q    <= bet_d;
         credit_q <= credit_d;
         won_q    <= won_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         reels_q  <= reels_d;
         win_q    <= win_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      bet_d    = bet_q;
      credit_d = credit_q;
      won_d    = won_q;
      cnt_d    = cnt_q;
      reels_d  = reels_q;
      win_d    = win_q;
      step_sum = '0;
      sum      = 32'(credit_q) + win_q;
      jack     = 32'(bet_q) * 32'(JACKPOT_MUL);

      // A single reel is trivially "all equal", so the loop is simply empty then.
      all_eq = 1'b1;
      adj_eq = 1'b0;
      for (int k = 1; k < NUM_REELS; k++) begin
         if (reels_q[4*k +: 4] != reels_q[3:0])       all_eq = 1'b0;
         if (reels_q[4*k +: 4] == reels_q[4*k-4 +: 4]) adj_eq = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (credit_q >= CREDIT_W'(bet_q)) begin
                  state_d  = SPIN;
                  credit_d = credit_q - CREDIT_W'(bet_q);
                  won_d    = 1'b0;
                  cnt_d    = '0;
               end
            end else if (bus.mode) begin
               mode_d = (32'(mode_q) >= 32'(NUM_MODES)) ? MODE_W'(1) : mode_q + MODE_W'(1);
            end else if (bus.betinp) begin
               if (32'(bet_q) < 32'(BET_MAX)) bet_d = bet_q + 4'd1;
            end else if (bus.betinm) begin
               if (bet_q > 4'd1) bet_d = bet_q - 4'd1;
            end
         end
         SPIN: begin
            cnt_d = cnt_q + CNT_W'(1);
            // Reel k keeps stepping by 2k+1 until its own stop point, so reels stop in order.
            for (int k = 0; k < NUM_REELS; k++) begin
               if (32'(cnt_q) < 32'(SPIN_CYCLES * (k + 1))) begin
                  step_sum = {1'b0, reels_q[4*k +: 4]} + 5'(2 * k + 1);
                  reels_d[4*k +: 4] = (step_sum >= 5'd10) ? 4'(step_sum - 5'd10) : step_sum[3:0];
               end
            end
            if (32'(cnt_q) == 32'(TOTAL - 1)) state_d = EVAL;
         end
         EVAL: begin
            if (all_eq)
               win_d = (32'(mode_q) >= 32'd3) ? jack * (32'(mode_q) - 32'd1) : jack;
            else if (32'(mode_q) == 32'd2 && adj_eq)
               win_d = 32'(bet_q) * 32'd2;
            else
               win_d = '0;
            state_d = PAYOUT;
         end
         PAYOUT: begin
            credit_d = (sum > CREDIT_MAX) ? CREDIT_W'(CREDIT_MAX) : CREDIT_W'(sum);
            won_d    = (win_q != '0);
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign bus.mode_num = mode_q;
   assign bus.bet      = bet_q;
   assign bus.credit   = credit_q;
   assign bus.won      = won_q;
   assign bus.busy     = busy_q;
   assign bus.out      = reels_q;
endmodule

// File: tb/tb_slot_machine_core.sv
// tb/tb_slot_machine_core.sv - scoreboard bench for slot_machine_core
// A game-level model pushes each expected outcome at start; it is popped when busy falls.
module tb_slot_machine_core;
   localparam int N  = 3;
   localparam int NM = 3;
   localparam int SC = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   slot_machine_core_if #(.NUM_REELS(N), .NUM_MODES(NM), .CREDIT_W(8)) bus ();

   slot_machine_core #(
      .NUM_REELS(N), .NUM_MODES(NM), .SPIN_CYCLES(SC), .BET_MAX(9),
      .CREDIT_W(8), .INIT_CREDIT(20), .JACKPOT_MUL(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [4*N-1:0] reels;
      logic [7:0]     credit;
      logic           won;
      int             lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   m_reels[N];
   int   m_credit, m_bet, m_mode;

   task automatic model_reset();
      for (int k = 0; k < N; k++) m_reels[k] = 0;
      m_credit = 20;
      m_bet    = 1;
      m_mode   = 1;
   endtask

   task automatic model_game();
      exp_t e;
      bit   all_eq, adj;
      int   win;
      m_credit -= m_bet;
      for (int k = 0; k < N; k++) m_reels[k] = (m_reels[k] + (2*k + 1) * SC * (k + 1)) % 10;
      all_eq = 1'b1;
      adj    = 1'b0;
      for (int k = 1; k < N; k++) begin
         if (m_reels[k] != m_reels[0])   all_eq = 1'b0;
         if (m_reels[k] == m_reels[k-1]) adj    = 1'b1;
      end
      if (all_eq)                  win = m_bet * 8 * ((m_mode >= 3) ? m_mode - 1 : 1);
      else if (m_mode == 2 && adj) win = m_bet * 2;
      else                         win = 0;
      m_credit = (m_credit + win > 255) ? 255 : m_credit + win;
      for (int k = 0; k < N; k++) e.reels[4*k +: 4] = 4'(m_reels[k]);
      e.credit = 8'(m_credit);
      e.won    = (win != 0);
      e.lat    = SC * N + 3;
      sb.push_back(e);
   endtask

   task automatic pulse(input int which, input int n);
      repeat (n) begin
         @(negedge clk);
         bus.mode   = (which == 0);
         bus.betinp = (which == 1);
         bus.betinm = (which == 2);
         @(negedge clk);
         bus.mode   = 1'b0;
         bus.betinp = 1'b0;
         bus.betinm = 1'b0;
         if (which == 0) m_mode = (m_mode == NM) ? 1 : m_mode + 1;
         if (which == 1) m_bet  = (m_bet < 9) ? m_bet + 1 : 9;
         if (which == 2) m_bet  = (m_bet > 1) ? m_bet - 1 : 1;
      end
   endtask

   task automatic run_game(input bit with_mode, input bit lock_pulses);
      exp_t e;
      int   lat;
      bit   done;
      if (m_credit >= m_bet) model_game();
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = with_mode;
      lat  = 0;
      done = 1'b0;
      while (!done && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         bus.start  = 1'b0;
         bus.mode   = lock_pulses && (lat == 3);
         bus.betinp = lock_pulses && (lat == 5);
         bus.betinm = lock_pulses && (lat == 7);
         done = !bus.busy;
      end
      bus.mode = 1'b0; bus.betinp = 1'b0; bus.betinm = 1'b0;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty got busy=%0b want queued result", bus.busy);
         return;
      end
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL latency got %0d want %0d", lat, e.lat); end
      checks++;
      if (bus.out !== e.reels) begin errors++; $display("FAIL reels got %h want %h", bus.out, e.reels); end
      checks++;
      if (bus.credit !== e.credit) begin errors++; $display("FAIL credit got %0d want %0d", bus.credit, e.credit); end
      checks++;
      if (bus.won !== e.won) begin errors++; $display("FAIL won got %0b want %0b", bus.won, e.won); end
      checks++;
      if (bus.mode_num !== 2'(m_mode)) begin errors++; $display("FAIL game_mode got %0d want %0d", bus.mode_num, m_mode); end
      checks++;
      if (bus.bet !== 4'(m_bet)) begin errors++; $display("FAIL game_bet got %0d want %0d", bus.bet, m_bet); end
   endtask

   task automatic check_idle_state(input string tag);
      checks++;
      if (bus.busy !== 1'b0 || bus.credit !== 8'd20 || bus.out !== '0 || bus.mode_num !== 2'd1
          || bus.bet !== 4'd1 || bus.won !== 1'b0) begin
         errors++;
         $display("FAIL %s got busy=%0b credit=%0d out=%h mode=%0d bet=%0d won=%0b want 0/20/000/1/1/0",
                  tag, bus.busy, bus.credit, bus.out, bus.mode_num, bus.bet, bus.won);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      check_idle_state("reset_defaults");
   endtask

   task automatic test_adjacent_pair();
      pulse(0, 1);
      pulse(1, 2);
      run_game(1'b0, 1'b0);
      checks++;
      if (bus.out !== 12'h044 || bus.credit !== 8'd23 || bus.won !== 1'b1) begin
         errors++;
         $display("FAIL adjacent_pair got out=%h credit=%0d won=%0b want 044/23/1", bus.out, bus.credit, bus.won);
      end
   endtask

   task automatic test_bet_saturation();
      pulse(1, 12);
      checks++;
      if (bus.bet !== 4'd9) begin errors++; $display("FAIL bet_max got %0d want 9", bus.bet); end
      pulse(2, 10);
      checks++;
      if (bus.bet !== 4'd1) begin errors++; $display("FAIL bet_min got %0d want 1", bus.bet); end
   endtask

   task automatic test_spin_lock();
      run_game(1'b0, 1'b1);
   endtask

   task automatic test_priority();
      run_game(1'b1, 1'b0);
      run_game(1'b0, 1'b0);
   endtask

   task automatic test_jackpot();
      pulse(0, 1);
      pulse(1, 8);
      run_game(1'b0, 1'b0);
      checks++;
      if (bus.out !== 12'h000 || bus.credit !== 8'd161 || bus.won !== 1'b1) begin
         errors++;
         $display("FAIL jackpot_mode3 got out=%h credit=%0d won=%0b want 000/161/1", bus.out, bus.credit, bus.won);
      end
   endtask

   task automatic test_back_to_back();
      pulse(2, 8);
      for (int i = 0; i < 4; i++) run_game(1'b0, 1'b0);
      checks++;
      if (bus.credit !== 8'd157 || bus.won !== 1'b0) begin
         errors++;
         $display("FAIL losing_run got credit=%0d won=%0b want 157/0", bus.credit, bus.won);
      end
   endtask

   task automatic test_credit_saturation();
      pulse(1, 8);
      run_game(1'b0, 1'b0);
      checks++;
      if (bus.credit !== 8'd255) begin errors++; $display("FAIL credit_sat got %0d want 255", bus.credit); end
   endtask

   task automatic test_reset_mid_spin();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL spin_started got busy=%0b want 1", bus.busy); end
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      check_idle_state("reset_mid_spin");
   endtask

   task automatic test_insufficient_credit();
      pulse(1, 8);
      run_game(1'b0, 1'b0);
      run_game(1'b0, 1'b0);
      checks++;
      if (bus.credit !== 8'd2) begin errors++; $display("FAIL drain_credit got %0d want 2", bus.credit); end
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (bus.busy !== 1'b0 || bus.credit !== 8'd2) begin
            errors++;
            $display("FAIL start_ignored got busy=%0b credit=%0d want 0/2", bus.busy, bus.credit);
         end
      end
   endtask

   initial begin
      bus.mode = 1'b0; bus.start = 1'b0; bus.betinp = 1'b0; bus.betinm = 1'b0;
      test_reset();
      test_adjacent_pair();
      test_bet_saturation();
      test_spin_lock();
      test_priority();
      test_jackpot();
      test_back_to_back();
      test_credit_saturation();
      test_reset_mid_spin();
      test_insufficient_credit();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/slot_machine_core.md
Name: slot_machine_core

Overview:
Parametrised successor to the three-mode slot machine top level. It replaces the per-mode game instances and the combinational mode multiplexer with a single clocked game engine. The engine has N reels, N game modes, bet/credit accounting with saturation, and mode changes locked while a spin is in progress. It sits between the synchronised button pulses and the 7-segment/LED display logic.

Parameters:
NUM_REELS, 3, number of reels (1..5); each reel is one BCD digit 0..9
NUM_MODES, 3, number of game modes (>=1); mode_num ranges 1..NUM_MODES
SPIN_CYCLES, 16, cycles per reel stop stage (>=1)
BET_MAX, 9, maximum bet (1..15)
CREDIT_W, 8, credit register width
INIT_CREDIT, 20, credit value after reset (< 2^CREDIT_W)
JACKPOT_MUL, 8, base payout multiplier for all-equal reels

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
mode  in  1  one-cycle pulse: advance game mode
start  in  1  one-cycle pulse: start spin
betinp  in  1  one-cycle pulse: bet +1
betinm  in  1  one-cycle pulse: bet -1
mode_num  out  clog2(NUM_MODES+1)  current mode, 1-based
bet  out  4  current bet
credit  out  CREDIT_W  current credit
won  out  1  last finished game paid out
busy  out  1  high in every state except IDLE
out  out  4*NUM_REELS  reel digits; reel k occupies bits [4k+3:4k]

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, mode_num=1, bet=1, credit=INIT_CREDIT, won=0, busy=0, all reels=0, spin counter=0.
  - Reset mid-spin aborts the spin; no payout, no refund.
- Input pulses are ignored in every state except IDLE.
- In IDLE, priority is start > mode > betinp > betinm; only the highest-priority pulse present acts that cycle.
- mode: mode_num increments; NUM_MODES wraps to 1. If NUM_MODES==1 it stays 1.
- betinp: bet+1, saturating at BET_MAX. betinm: bet-1, saturating at 1.
- start, accepted only if credit >= bet:
  - Next edge: state=SPIN, credit -= bet, won=0, counter=0, busy=1.
  - If credit < bet, start is ignored and nothing changes.
- SPIN, every cycle:
  - counter += 1.
  - Reel k advances by step (2k+1), mod 10, while counter < SPIN_CYCLES*(k+1).
  - So reel k advances exactly SPIN_CYCLES*(k+1) times, and reels stop in order 0,1,...
  - On the edge where counter == SPIN_CYCLES*NUM_REELS-1 (last reel's final step), go to EVAL.
- EVAL (1 cycle): compute win from the frozen reels and mode_num.
  - mode 1: all reels equal -> bet*JACKPOT_MUL; else 0.
  - mode 2: all equal -> bet*JACKPOT_MUL; else any adjacent pair equal (reel k == reel k+1) -> bet*2; else 0.
  - mode m>=3: all equal -> bet*JACKPOT_MUL*(m-1); else 0.
  - NUM_REELS==1: "all equal" is always true.
- PAYOUT (1 cycle):
  - credit += win, saturating at 2^CREDIT_W-1.
  - won = (win != 0); won holds until the next accepted start or reset.
  - Next state IDLE.
- Latency: accepted start to busy falling = SPIN_CYCLES*NUM_REELS + 3 edges.
- Reels are not cleared between games; each game starts from the previous final reel values.
- All outputs are registered.

Test Plan:
- Reset/defaults: hold rst=0 for 2 cycles -> mode_num=1, bet=1, credit=20, won=0, busy=0, out=0.
- Adjacent-pair win, mode 2 (SPIN_CYCLES=4, NUM_REELS=3):
  - Setup from reset: mode pulse once, bet=3, start.
  - Required: reels end {reel2,reel1,reel0}={0,4,4}, credit=20-3+6=23, won=1, busy high for 15 edges.
- Jackpot, mode 1 (SPIN_CYCLES=10) from reset, bet=1, start:
  - Required: all reels return to 0, credit=20-1+8=27, won=1.
- Same spin in mode 3 with bet=2: credit=20-2+32=50.
- Saturation and locking:
  - 12 betinp pulses -> bet=9; 10 betinm pulses -> bet=1.
  - mode/bet pulses during SPIN -> no change.
  - Credit at 250, CREDIT_W=8, jackpot of 72 -> credit=255.
- Insufficient credit and priority:
  - Credit 2, bet 3, start -> ignored, busy stays 0.
  - start+mode in the same IDLE cycle -> spin starts, mode_num unchanged.
  - rst=0 mid-SPIN -> IDLE with credit=INIT_CREDIT next edge.
